yarp_mem_responder: RTL and testbench
=====================================

# yarp_mem_responder

Memory-side responder for the core's fetch/load-store request interface. It accepts one word-granular request per cycle from an initiator such as the instruction-fetch stage or the data-memory stage, services reads from an internal word array, and commits writes with byte enables. Read data returns after a fixed, parameterised latency through a response pipeline. It is the simulation/FPGA memory behind the fetch and LSU ports.

## Interface
- MEM_DEPTH_WORDS, 1024: number of 32-bit words in the array; power of two, 16..65536.
- RD_LATENCY, 1: request-to-response latency in cycles; legal range 1..4.
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous reset, active-high.
- mem_req_i  in  1  request valid this cycle; no grant, always accepted.
- mem_addr_i  in  32  byte address; bits [1:0] must be 0.
- mem_wr_i  in  1  1 = write, 0 = read; qualified by mem_req_i.
- mem_be_i  in  4  byte enables for writes; bit n covers wr_data[8n+7:8n]; ignored on reads.
- mem_wr_data_i  in  32  write data.
- mem_rd_data_o  out  32  read data; valid when mem_rd_valid_o=1, otherwise holds its last value.
- mem_rd_valid_o  out  1  read response strobe.
- mem_err_o  out  1  error strobe for the request issued RD_LATENCY cycles earlier.

## Operation
- Word index is mem_addr_i[31:2]. The request is in range when the index is < MEM_DEPTH_WORDS.
- A request is bad when mem_addr_i[1:0] != 0 or it is out of range.
- Good read: the array word is captured at acceptance.
- Bad read: data 0. It enters the pipeline as valid=1, err=1.
- Good write: the byte lanes with be=1 are written on the acceptance edge. Lanes with be=0 are unchanged. mem_be_i=0 is a legal no-op write.
- Bad write: the array is not modified. It enters the pipeline as valid=0, err=1.
- A good write never produces a response.
- Fully pipelined: back-to-back requests are accepted every cycle, with no bubbles and no stalls.
- Read-after-write to the same word in the next cycle returns the new data. The write commits before that read's array access.
- Array contents are not affected by reset and power up as 0.
- On reset:
  - The pipeline is cleared.
  - mem_rd_valid_o=0, mem_err_o=0, mem_rd_data_o=0.
  - Any request presented during reset is ignored, including writes.

## Timing
- Request accepted at edge t, when mem_req_i=1 and reset=0.
- Response outputs change at edge t+RD_LATENCY−1 and are observed during cycle t+RD_LATENCY−1 to t+RD_LATENCY. For RD_LATENCY=1 they are registered outputs, valid in the cycle after the request.
- Responses return strictly in request order; one response slot per cycle.
- mem_rd_valid_o and mem_err_o are single-cycle strobes per request.
- mem_rd_data_o updates only when a read response is delivered; it holds between responses.
- Reset asserted mid-flight:
  - All in-flight responses are dropped; none appear after reset deasserts.
  - The first request accepted after reset has its response RD_LATENCY cycles later.
- The fetch stage drives req=1 continuously with a new PC each cycle. This yields one instruction per cycle, offset by RD_LATENCY.

## Structure
- yarp_pkg additions:
  - MEM_WORD_BYTES=4.
  - typedef mem_resp_t, a packed struct {valid, err, data[31:0]}.
  - function mem_addr_ok(addr, depth) returning the good/bad decision.
- Sub-module yarp_mem_resp_pipe:
  - RD_LATENCY−1 stages of mem_resp_t after the first capture register.
  - Synchronous clear on reset.
  - The stage count is parameterised with a generate loop.
- Top level holds the array, the address check, the byte-enable write and the capture register.

## Test plan
- Reset check: assert reset for 3 cycles with mem_req_i=1 throughout.
  - No strobes during or after reset; mem_rd_data_o=0.
  - A read of word 0 after reset returns 0x00000000 with valid.
- Byte-enable write/read-back: write 0xDEADBEEF to 0x10 with be=4'b1111, then write 0x000000AA with be=4'b0001, then read 0x10.
  - The read returns 0xDEADBEAA exactly RD_LATENCY cycles after the read.
- Streaming fetch: preload words 0..7 = index*0x11111111, then drive 8 back-to-back reads at 0x00..0x1C. Run for RD_LATENCY=1 and RD_LATENCY=3.
  - 8 consecutive valid strobes in order, with no gaps.
- Errors:
  - Read at 0x00000006 → valid=1, err=1, data=0.
  - Write at MEM_DEPTH_WORDS*4 → err=1, valid=0.
  - A later read of word 0 is unchanged.
- Write then read next cycle: write 0x12345678 to 0x40, then read 0x40 on the following cycle.
  - The read returns 0x12345678.
- Mid-flight reset: with RD_LATENCY=4, issue 3 reads, then assert reset for 1 cycle after the 2nd read.
  - Zero strobes for all 3 reads.
  - A read issued after reset is answered 4 cycles later.

Source files
------------

// File: rtl/yarp_pkg.sv
// yarp_pkg: shared memory-responder types, constants and address check
// Contents:
//   MEM_WORD_BYTES - bytes per array word (one byte enable per lane)
//   mem_resp_t     - response slot {valid, err, data} carried down the pipe
//   mem_addr_ok    - 1 when a byte address is word aligned and inside the array
package yarp_pkg;

    localparam int MEM_WORD_BYTES = 4;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } mem_resp_t;

    function automatic logic mem_addr_ok(input logic [31:0] addr, input logic [31:0] depth);
        return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
    endfunction

endpackage

// File: rtl/yarp_mem_resp_pipe.sv
// yarp_mem_resp_pipe: delay line of response slots behind the capture register
// Ports:
//   clk    - core clock
//   reset  - synchronous active-high clear of every stage
//   resp_i - response slot from the capture register
//   resp_o - response slot after STAGES cycles
module yarp_mem_resp_pipe
    import yarp_pkg::*;
#(
    parameter int STAGES = 1
) (
    input  logic      clk,
    input  logic      reset,
    input  mem_resp_t resp_i,
    output mem_resp_t resp_o
);

    mem_resp_t chain [STAGES+1];

    assign chain[0] = resp_i;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        mem_resp_t stage_d;
        mem_resp_t stage_q;

        // Data only moves with a read response so the output word holds between responses.
        always_comb begin
            stage_d      = chain[i];
            stage_d.data = chain[i].valid ? chain[i].data : stage_q.data;
        end

        always_ff @(posedge clk) begin
            if (reset) stage_q <= '0;
            else       stage_q <= stage_d;
        end

        assign chain[i+1] = stage_q;
    end

    assign resp_o = chain[STAGES];

endmodule

// File: rtl/yarp_mem_responder.sv
// yarp_mem_responder: word memory behind the fetch/LSU request port
// Ports:
//   clk            - core clock
//   reset          - synchronous active-high; clears responses, blocks requests
//   mem_req_i      - request valid, always accepted
//   mem_addr_i     - byte address, must be word aligned
//   mem_wr_i       - 1 write, 0 read
//   mem_be_i       - write byte enables, one per lane
//   mem_wr_data_i  - write data
//   mem_rd_data_o  - read data, holds between read responses
//   mem_rd_valid_o - read response strobe
//   mem_err_o      - bad-request strobe, RD_LATENCY cycles after acceptance
module yarp_mem_responder
    import yarp_pkg::*;
#(
    parameter int MEM_DEPTH_WORDS = 1024,
    parameter int RD_LATENCY      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req_i,
    input  logic [31:0] mem_addr_i,
    input  logic        mem_wr_i,
    input  logic [3:0]  mem_be_i,
    input  logic [31:0] mem_wr_data_i,
    output logic [31:0] mem_rd_data_o,
    output logic        mem_rd_valid_o,
    output logic        mem_err_o
);

    localparam int AW = $clog2(MEM_DEPTH_WORDS);

    // Not reset: contents survive reset and rely on power-up zero.
    logic [31:0] mem_array [MEM_DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic          accept;
    logic          good;
    logic          rd_valid;
    logic          wr_en;
    mem_resp_t     cap_d;
    mem_resp_t     cap_q;
    mem_resp_t     resp;

    always_comb begin
        idx        = mem_addr_i[AW+1:2];
        accept     = mem_req_i & ~reset;
        good       = mem_addr_ok(mem_addr_i, 32'(MEM_DEPTH_WORDS));
        rd_valid   = accept & ~mem_wr_i;
        wr_en      = accept & mem_wr_i & good;
        cap_d.valid = rd_valid;
        cap_d.err   = accept & ~good;
        // Bad reads return zero; non-read cycles keep the previous word.
        cap_d.data  = rd_valid ? (good ? mem_array[idx] : '0) : cap_q.data;
    end

    always_ff @(posedge clk) begin
        if (reset) cap_q <= '0;
        else       cap_q <= cap_d;
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < MEM_WORD_BYTES; b++) begin
            if (wr_en && mem_be_i[b]) mem_array[idx][8*b +: 8] <= mem_wr_data_i[8*b +: 8];
        end
    end

    if (RD_LATENCY > 1) begin : g_pipe
        yarp_mem_resp_pipe #(
            .STAGES(RD_LATENCY - 1)
        ) u_pipe (
            .clk    (clk),
            .reset  (reset),
            .resp_i (cap_q),
            .resp_o (resp)
        );
    end else begin : g_direct
        assign resp = cap_q;
    end

    assign mem_rd_valid_o = resp.valid;
    assign mem_err_o      = resp.err;
    assign mem_rd_data_o  = resp.data;

endmodule

// File: tb/tb_yarp_mem_responder.sv
// tb_yarp_mem_responder: scoreboard bench driving RD_LATENCY 1, 3 and 4 instances in lockstep
module tb_yarp_mem_responder;

    localparam int DEPTH = 1024;

    typedef struct {
        logic        valid;
        logic        err;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req_i;
    logic [31:0] mem_addr_i;
    logic        mem_wr_i;
    logic [3:0]  mem_be_i;
    logic [31:0] mem_wr_data_i;
    logic [31:0] rd_data [3];
    logic        rd_valid [3];
    logic        err [3];

    int          cyc = 0;
    logic        rst_edge = 1'b1;
    int          vectors = 0;
    int          miscompares = 0;
    exp_t        sb [3][$];
    logic [31:0] last_d [3];
    logic [31:0] model [DEPTH];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        yarp_mem_responder #(
            .MEM_DEPTH_WORDS (DEPTH),
            .RD_LATENCY      (k == 0 ? 1 : (k == 1 ? 3 : 4))
        ) dut (
            .clk            (clk),
            .reset          (reset),
            .mem_req_i      (mem_req_i),
            .mem_addr_i     (mem_addr_i),
            .mem_wr_i       (mem_wr_i),
            .mem_be_i       (mem_be_i),
            .mem_wr_data_i  (mem_wr_data_i),
            .mem_rd_data_o  (rd_data[k]),
            .mem_rd_valid_o (rd_valid[k]),
            .mem_err_o      (err[k])
        );
    end

    function automatic int lat(input int k);
        return k == 0 ? 1 : (k == 1 ? 3 : 4);
    endfunction

    task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= reset;
    end

    // Every cycle each instance either delivers the scheduled response or stays quiet with held data.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst_edge) begin
                check($sformatf("reset_L%0d", lat(k)), {rd_valid[k], err[k], rd_data[k]}, 34'd0);
                last_d[k] = '0;
            end else if (sb[k].size() != 0 && sb[k][0].due == cyc) begin
                exp_t x;
                x = sb[k].pop_front();
                check($sformatf("resp_L%0d", lat(k)), {rd_valid[k], err[k], rd_data[k]},
                      {x.valid, x.err, x.valid ? x.data : last_d[k]});
                if (x.valid) last_d[k] = x.data;
            end else begin
                check($sformatf("idle_L%0d", lat(k)), {rd_valid[k], err[k], rd_data[k]},
                      {2'b00, last_d[k]});
            end
        end
    end

    task automatic drive(input logic rst, input logic req, input logic wr, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] data);
        logic good;
        int   w;
        reset         = rst;
        mem_req_i     = req;
        mem_wr_i      = wr;
        mem_addr_i    = addr;
        mem_be_i      = be;
        mem_wr_data_i = data;
        good          = (addr[1:0] == 2'b00) && ((addr >> 2) < DEPTH);
        w             = int'(addr >> 2) % DEPTH;
        if (rst) begin
            // Responses not yet delivered before the reset edge are lost.
            for (int k = 0; k < 3; k++)
                while (sb[k].size() != 0 && sb[k][$].due > cyc) void'(sb[k].pop_back());
        end else if (req) begin
            if (wr && good) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model[w][8*b +: 8] = data[8*b +: 8];
            end else begin
                for (int k = 0; k < 3; k++)
                    sb[k].push_back('{valid: !wr, err: !good,
                                      data: (!wr && good) ? model[w] : 32'h0, due: cyc + lat(k)});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] addr);
        drive(1'b0, 1'b1, 1'b0, addr, 4'h0, 32'h0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
        drive(1'b0, 1'b1, 1'b1, addr, be, data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        for (int k = 0; k < 3; k++) last_d[k] = '0;

        // Reset with a write held on the port: must be ignored.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 32'h0, 4'hF, 32'hFFFF_FFFF);
        idle(2);
        rd(32'h0);
        idle(5);

        // Byte-enable merge.
        wr(32'h10, 4'hF, 32'hDEAD_BEEF);
        wr(32'h10, 4'h1, 32'h0000_00AA);
        rd(32'h10);
        idle(5);

        // Streaming fetch.
        for (int i = 0; i < 8; i++) wr(32'(i * 4), 4'hF, 32'(i) * 32'h1111_1111);
        for (int i = 0; i < 8; i++) rd(32'(i * 4));
        idle(5);

        // Error cases, including an out-of-range write that would alias word 0 if truncated.
        rd(32'h6);
        wr(32'(DEPTH * 4), 4'hF, 32'hCAFE_F00D);
        rd(32'h0);
        rd(32'(DEPTH * 4 - 4));
        rd(32'(DEPTH * 4));
        wr(32'h8, 4'hF, 32'h5555_5555);
        wr(32'h9, 4'hF, 32'hAAAA_AAAA);
        rd(32'h8);
        idle(5);

        // Zero-enable write is a no-op.
        wr(32'h10, 4'h0, 32'h0BAD_0BAD);
        rd(32'h10);

        // Read immediately after write.
        wr(32'h40, 4'hF, 32'h1234_5678);
        rd(32'h40);
        idle(5);

        // Reset in the middle of a read burst.
        rd(32'h4);
        rd(32'h8);
        drive(1'b1, 1'b1, 1'b0, 32'hC, 4'h0, 32'h0);
        rd(32'h1C);
        idle(6);

        // Random mixed traffic over a small window.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 15)) * 4;
            if ($urandom_range(0, 9) == 0) a = a | 32'h2;
            if ($urandom_range(0, 1) == 1) wr(a, 4'($urandom_range(0, 15)), $urandom);
            else if ($urandom_range(0, 3) == 0) idle(1);
            else rd(a);
        end
        idle(8);

        for (int k = 0; k < 3; k++)
            check($sformatf("drained_L%0d", lat(k)), 34'(sb[k].size()), 34'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
